// File: rtl/retire_mon_pkg.sv
// retire_mon_pkg: shared types and tohost verdict helpers for retire_monitor.
// Optional feature macro used by the monitor: RETIRE_MON_HIST_EN (PC history ring).
package retire_mon_pkg;

    // Monitor run-control states; encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mon_state_e;

    // Reason for a failing verdict.
    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TOHOST  = 2'd1,
        FC_STALL   = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_e;

    // tohost value 1 (lsb set, all upper bits clear) signals a passing test.
    function automatic logic tohost_is_pass(input logic lsb, input logic upper_zero);
        return lsb & upper_zero;
    endfunction

    // Any other odd tohost value reports a failing test id in the upper bits.
    function automatic logic tohost_is_fail(input logic lsb, input logic upper_zero);
        return lsb & ~upper_zero;
    endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// retire_monitor_if: retirement and store observation bus from the core to the monitor.
interface retire_monitor_if #(
    parameter int XLEN = 32
);
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;

    // Core side drives the observation signals.
    modport master (
        output ret_valid, ret_pc, st_valid, st_addr, st_data
    );

    // Monitor side only observes.
    modport slave (
        input ret_valid, ret_pc, st_valid, st_addr, st_data
    );
endinterface

// File: rtl/pc_history_ring.sv
// pc_history_ring: circular buffer of the most recently retired PCs.
// Read index 0 is the newest entry; entries not written since the last clear read 0.
module pc_history_ring #(
    parameter int HIST_DEPTH = 8,
    parameter int XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [XLEN-1:0]               wr_data,
    input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]               rd_data
);
    localparam int IDX_W  = $clog2(HIST_DEPTH);
    localparam int FILL_W = IDX_W + 1;
    localparam logic [IDX_W-1:0]  IDX_ONE_C  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] FILL_ONE_C = {{(FILL_W-1){1'b0}}, 1'b1};
    localparam logic [FILL_W-1:0] DEPTH_C    = FILL_W'(HIST_DEPTH);

    logic [XLEN-1:0]   mem_r [HIST_DEPTH];
    logic [IDX_W-1:0]  wr_ptr_r;
    logic [FILL_W-1:0] fill_r;
    logic [IDX_W-1:0]  rd_addr_s;
    logic              rd_valid_s;

    // Write pointer, fill level and storage; clear restarts the ring without wiping data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            fill_r   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_r <= '0;
            fill_r   <= '0;
        end else if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + IDX_ONE_C;
            fill_r          <= (fill_r == DEPTH_C) ? fill_r : fill_r + FILL_ONE_C;
        end else begin
            wr_ptr_r <= wr_ptr_r;
            fill_r   <= fill_r;
        end
    end

    // Newest-first read; slots beyond the fill level are masked to zero.
    always_comb begin
        rd_addr_s  = wr_ptr_r - IDX_ONE_C - rd_idx;
        rd_valid_s = ({1'b0, rd_idx} < fill_r);
        if (rd_valid_s) begin
            rd_data = mem_r[rd_addr_s];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/retire_monitor.sv
// retire_monitor: run-control and self-check monitor for the 3-stage core.
// Watches retirements and tohost stores, decides pass/fail, enforces stall and
// global-cycle watchdogs. Define RETIRE_MON_HIST_EN to build the PC history ring;
// without it hist_pc reads 0 and hist_idx is ignored.
module retire_monitor
    import retire_mon_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int              STALL_LIMIT = 64,
    parameter int              MAX_CYCLES  = 100000,
    parameter int              HIST_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    retire_monitor_if.slave               obs,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [1:0]                    state,
    output logic                          done,
    output logic                          pass,
    output logic [1:0]                    fail_code,
    output logic [XLEN-1:0]               test_id,
    output logic [CNT_W-1:0]              cycle_cnt,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic [XLEN-1:0]               hist_pc
);
    localparam logic [CNT_W-1:0] CNT_ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STALL_LIMIT_C = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] MAX_CYCLES_C  = CNT_W'(MAX_CYCLES);

    mon_state_e       state_r;
    logic             done_r;
    logic             pass_r;
    fail_code_e       fail_code_r;
    logic [XLEN-1:0]  test_id_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic [CNT_W-1:0] cycle_next_s;
    logic [CNT_W-1:0] retire_next_s;
    logic [CNT_W-1:0] stall_next_s;
    logic             tohost_hit_s;
    logic             upper_zero_s;
    logic             tohost_pass_s;
    logic             tohost_fail_s;
    logic             stall_hit_s;
    logic             timeout_hit_s;

    // Next counter values (saturating) and the verdict conditions for a RUN cycle.
    always_comb begin
        cycle_next_s = (&cycle_cnt_r) ? cycle_cnt_r : cycle_cnt_r + CNT_ONE_C;
        if (obs.ret_valid) begin
            retire_next_s = (&retire_cnt_r) ? retire_cnt_r : retire_cnt_r + CNT_ONE_C;
            stall_next_s  = '0;
        end else begin
            retire_next_s = retire_cnt_r;
            stall_next_s  = (&stall_cnt_r) ? stall_cnt_r : stall_cnt_r + CNT_ONE_C;
        end
        tohost_hit_s  = obs.st_valid && (obs.st_addr == TOHOST_ADDR);
        upper_zero_s  = (obs.st_data[XLEN-1:1] == '0);
        tohost_pass_s = tohost_hit_s && tohost_is_pass(obs.st_data[0], upper_zero_s);
        tohost_fail_s = tohost_hit_s && tohost_is_fail(obs.st_data[0], upper_zero_s);
        stall_hit_s   = (stall_next_s >= STALL_LIMIT_C);
        timeout_hit_s = (cycle_next_s >= MAX_CYCLES_C);
    end

    // Run-control FSM with registered verdict outputs; tohost beats stall beats timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_code_r  <= FC_NONE;
            test_id_r    <= '0;
            cycle_cnt_r  <= '0;
            retire_cnt_r <= '0;
            stall_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    cycle_cnt_r  <= cycle_next_s;
                    retire_cnt_r <= retire_next_s;
                    stall_cnt_r  <= stall_next_s;
                    if (tohost_pass_s) begin
                        state_r <= ST_PASS;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                    end else if (tohost_fail_s) begin
                        state_r     <= ST_FAIL;
                        done_r      <= 1'b1;
                        pass_r      <= 1'b0;
                        fail_code_r <= FC_TOHOST;
                        test_id_r   <= {1'b0, obs.st_data[XLEN-1:1]};
                    end else if (stall_hit_s) begin
                        state_r     <= ST_FAIL;
                        done_r      <= 1'b1;
                        pass_r      <= 1'b0;
                        fail_code_r <= FC_STALL;
                    end else if (timeout_hit_s) begin
                        state_r     <= ST_FAIL;
                        done_r      <= 1'b1;
                        pass_r      <= 1'b0;
                        fail_code_r <= FC_TIMEOUT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    // Outside RUN everything holds until a start re-arms with clears.
                    if (start) begin
                        state_r      <= ST_RUN;
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        fail_code_r  <= FC_NONE;
                        test_id_r    <= '0;
                        cycle_cnt_r  <= '0;
                        retire_cnt_r <= '0;
                        stall_cnt_r  <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    done_r       <= 1'b0;
                    pass_r       <= 1'b0;
                    fail_code_r  <= FC_NONE;
                    test_id_r    <= '0;
                    cycle_cnt_r  <= '0;
                    retire_cnt_r <= '0;
                    stall_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign state      = state_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign fail_code  = fail_code_r;
    assign test_id    = test_id_r;
    assign cycle_cnt  = cycle_cnt_r;
    assign retire_cnt = retire_cnt_r;

`ifdef RETIRE_MON_HIST_EN
    logic hist_clear_s;
    logic hist_wr_s;

    // History restarts on every arming start and records only RUN-cycle retirements.
    always_comb begin
        hist_clear_s = start && (state_r != ST_RUN);
        hist_wr_s    = (state_r == ST_RUN) && obs.ret_valid;
    end

    pc_history_ring #(
        .HIST_DEPTH (HIST_DEPTH),
        .XLEN       (XLEN)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .clear   (hist_clear_s),
        .wr_en   (hist_wr_s),
        .wr_data (obs.ret_pc),
        .rd_idx  (hist_idx),
        .rd_data (hist_pc)
    );
`else
    logic unused_hist_s;
    assign unused_hist_s = ^{hist_idx, obs.ret_pc};
    assign hist_pc       = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed self-checking bench for retire_monitor
// (STALL_LIMIT=16, MAX_CYCLES=50, HIST_DEPTH=8).
module tb_retire_monitor;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;
`ifdef RETIRE_MON_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       hist_idx;
    logic [1:0]       state;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [XLEN-1:0]  test_id;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [XLEN-1:0]  hist_pc;

    int total = 0;
    int bad   = 0;

    retire_monitor_if #(.XLEN(XLEN)) obs_if ();

    retire_monitor #(
        .XLEN        (XLEN),
        .CNT_W       (CNT_W),
        .TOHOST_ADDR (32'h0000_1000),
        .STALL_LIMIT (16),
        .MAX_CYCLES  (50),
        .HIST_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .obs        (obs_if),
        .hist_idx   (hist_idx),
        .state      (state),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .test_id    (test_id),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt),
        .hist_pc    (hist_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_verdict(input string tag, input logic [1:0] st, input logic dn,
                               input logic ps, input logic [1:0] fc);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".pass"}, 64'(pass), 64'(ps));
        chk({tag, ".fail_code"}, 64'(fail_code), 64'(fc));
    endtask

    task automatic chk_hist(input string tag, input logic [2:0] idx, input logic [31:0] val);
        hist_idx = idx;
        #1;
        chk(tag, 64'(hist_pc), HIST_ON ? 64'(val) : 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        obs_if.st_valid = 1'b1;
        obs_if.st_addr  = addr;
        obs_if.st_data  = data;
    endtask

    task automatic no_store();
        obs_if.st_valid = 1'b0;
        obs_if.st_addr  = 32'h0;
        obs_if.st_data  = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hist_idx = 3'd0;
        obs_if.ret_valid = 1'b0;
        obs_if.ret_pc = 32'h0;
        no_store();

        // Reset state
        #2;
        chk_verdict("rst", 2'd0, 1'b0, 1'b0, 2'd0);
        chk("rst.cycle", 64'(cycle_cnt), 64'd0);
        chk("rst.retire", 64'(retire_cnt), 64'd0);
        chk("rst.test_id", 64'(test_id), 64'd0);
        chk("rst.hist", 64'(hist_pc), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Pass run: 5 retirements then tohost=1
        pulse_start();
        chk("t1.run", 64'(state), 64'd1);
        chk("t1.cycle0", 64'(cycle_cnt), 64'd0);
        obs_if.ret_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            obs_if.ret_pc = 32'h100 + 32'(4 * i);
            tick();
        end
        obs_if.ret_valid = 1'b0;
        chk("t1.retire5", 64'(retire_cnt), 64'd5);
        store(32'h1000, 32'h1);
        tick();
        no_store();
        chk_verdict("t1.pass", 2'd2, 1'b1, 1'b1, 2'd0);
        chk("t1.retire", 64'(retire_cnt), 64'd5);
        chk("t1.cycle", 64'(cycle_cnt), 64'd6);
        obs_if.ret_valid = 1'b1;
        tick();
        tick();
        obs_if.ret_valid = 1'b0;
        chk("t1.frz_retire", 64'(retire_cnt), 64'd5);
        chk("t1.frz_cycle", 64'(cycle_cnt), 64'd6);
        chk_hist("t1.hist0", 3'd0, 32'h110);
        chk_hist("t1.hist4", 3'd4, 32'h100);
        chk_hist("t1.hist5", 3'd5, 32'h0);

        // Tohost fail: even data ignored, wrong address ignored, start in RUN ignored
        pulse_start();
        chk_verdict("t2.rearm", 2'd1, 1'b0, 1'b0, 2'd0);
        chk("t2.clr_retire", 64'(retire_cnt), 64'd0);
        chk_hist("t2.hist_clr", 3'd0, 32'h0);
        obs_if.ret_valid = 1'b1;
        store(32'h1000, 32'h4);
        tick();
        no_store();
        chk("t2.even_ign", 64'(state), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        obs_if.ret_valid = 1'b0;
        chk("t2.start_ign", 64'(cycle_cnt), 64'd2);
        store(32'h2000, 32'h7);
        tick();
        chk("t2.addr_ign", 64'(state), 64'd1);
        obs_if.ret_valid = 1'b1;
        store(32'h1000, 32'h7);
        tick();
        no_store();
        obs_if.ret_valid = 1'b0;
        chk_verdict("t2.fail", 2'd3, 1'b1, 1'b0, 2'd1);
        chk("t2.test_id", 64'(test_id), 64'd3);
        chk("t2.retire", 64'(retire_cnt), 64'd3);
        chk("t2.cycle", 64'(cycle_cnt), 64'd4);

        // Stall watchdog: retirement at idle count 15 restarts the count
        pulse_start();
        chk("t3.tid_clr", 64'(test_id), 64'd0);
        obs_if.ret_valid = 1'b1;
        tick();
        obs_if.ret_valid = 1'b0;
        repeat (15) tick();
        chk("t3.run15a", 64'(state), 64'd1);
        obs_if.ret_valid = 1'b1;
        tick();
        obs_if.ret_valid = 1'b0;
        repeat (15) tick();
        chk("t3.run15b", 64'(state), 64'd1);
        tick();
        chk_verdict("t3.stall", 2'd3, 1'b1, 1'b0, 2'd2);
        chk("t3.retire", 64'(retire_cnt), 64'd2);
        chk("t3.cycle", 64'(cycle_cnt), 64'd33);
        chk("t3.test_id", 64'(test_id), 64'd0);

        // Stall limit and tohost pass in the same cycle: pass wins
        pulse_start();
        repeat (15) tick();
        store(32'h1000, 32'h1);
        tick();
        no_store();
        chk_verdict("t4.prio", 2'd2, 1'b1, 1'b1, 2'd0);
        chk("t4.cycle", 64'(cycle_cnt), 64'd16);

        // History contents and global timeout with steady retirement
        pulse_start();
        obs_if.ret_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            obs_if.ret_pc = 32'(4 * i);
            tick();
        end
        chk_hist("t5.hist0", 3'd0, 32'h24);
        chk_hist("t5.hist3", 3'd3, 32'h18);
        chk_hist("t5.hist7", 3'd7, 32'h08);
        for (int i = 10; i < 49; i++) begin
            obs_if.ret_pc = 32'(4 * i);
            tick();
        end
        chk("t5.run49", 64'(state), 64'd1);
        chk("t5.cycle49", 64'(cycle_cnt), 64'd49);
        obs_if.ret_pc = 32'(4 * 49);
        tick();
        obs_if.ret_valid = 1'b0;
        chk_verdict("t5.timeout", 2'd3, 1'b1, 1'b0, 2'd3);
        chk("t5.cycle", 64'(cycle_cnt), 64'd50);
        chk("t5.retire", 64'(retire_cnt), 64'd50);
        chk_hist("t5.hist_wrap0", 3'd0, 32'hC4);
        chk_hist("t5.hist_wrap7", 3'd7, 32'hA8);

        // Asynchronous reset in the middle of a run, then a clean run
        pulse_start();
        obs_if.ret_valid = 1'b1;
        obs_if.ret_pc = 32'h200;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk_verdict("t6.rst", 2'd0, 1'b0, 1'b0, 2'd0);
        chk("t6.cycle", 64'(cycle_cnt), 64'd0);
        chk("t6.retire", 64'(retire_cnt), 64'd0);
        hist_idx = 3'd0;
        #1;
        chk("t6.hist", 64'(hist_pc), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("t6.idle_state", 64'(state), 64'd0);
        chk("t6.idle_retire", 64'(retire_cnt), 64'd0);
        obs_if.ret_valid = 1'b0;
        pulse_start();
        obs_if.ret_valid = 1'b1;
        obs_if.ret_pc = 32'h300;
        tick();
        obs_if.ret_pc = 32'h304;
        tick();
        obs_if.ret_valid = 1'b0;
        store(32'h1000, 32'h1);
        tick();
        no_store();
        chk_verdict("t6.pass", 2'd2, 1'b1, 1'b1, 2'd0);
        chk("t6.retire2", 64'(retire_cnt), 64'd2);
        chk("t6.cycle3", 64'(cycle_cnt), 64'd3);
        chk_hist("t6.hist0", 3'd0, 32'h304);
        chk_hist("t6.hist2", 3'd2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
